// File: rtl/sam_trace_pkg.sv
// ---------------------------------------------------------------------------
// sam_trace_pkg
// Shared definitions for the writeback trace buffer:
//   TRACE_DEPTH   default number of trace entries
//   TRACE_SEQW    default width of the sequence and drop counters
//   TRACE_PTR_W   pointer width for the default depth
//   trace_entry_t one stored entry {npc, wb, seq} at the default SEQW
//   entry_width() packed entry width for an arbitrary SEQW
// ---------------------------------------------------------------------------
package sam_trace_pkg;

   localparam int TRACE_DEPTH = 8;
   localparam int TRACE_SEQW  = 16;
   localparam int TRACE_PTR_W = $clog2(TRACE_DEPTH);

   typedef struct packed {
      logic [31:0]           npc;
      logic [31:0]           wb;
      logic [TRACE_SEQW-1:0] seq;
   } trace_entry_t;

   // Entries are stored as {npc, wb, seq}; the width follows the seq width.
   function automatic int entry_width(input int seqw);
      return 64 + seqw;
   endfunction

endpackage

// File: rtl/sam_trace_ram.sv
// ---------------------------------------------------------------------------
// sam_trace_ram
// DEPTH x WIDTH storage for trace entries: one synchronous write port and
// one asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk    clock
//   we     write enable, samples waddr/wdata on the rising edge
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data, combinational from raddr
// ---------------------------------------------------------------------------
module sam_trace_ram #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 80,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // NOTE: storage has no reset; validity is tracked by the control pointers,
   // so resetting the array would only cost flops without changing behaviour.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/sam_wb_trace_buf.sv
// ---------------------------------------------------------------------------
// sam_wb_trace_buf
// Captures core writeback events {npc, wb, seq} into a small FIFO and
// presents the oldest entry on a valid/ready output. Captures that arrive
// while the buffer is full (with no simultaneous pop) are dropped and
// counted; the sequence number still advances so gaps are visible.
// Ports:
//   clk       clock, rising edge
//   RN        asynchronous active-low reset
//   cap_en    capture enable
//   wb_valid  writeback strobe qualifying npc_in / wb_in
//   npc_in    next-PC at writeback
//   wb_in     writeback data
//   clear     synchronous flush of entries and counters (highest priority)
//   out_valid head entry available (== !empty)
//   out_ready consumer accepts head entry
//   out_npc   head entry NPC
//   out_wb    head entry writeback data
//   out_seq   head entry sequence number
//   count     current occupancy
//   full      count == DEPTH
//   empty     count == 0
//   drop_cnt  saturating count of captures lost while full
// ---------------------------------------------------------------------------
module sam_wb_trace_buf
   import sam_trace_pkg::*;
#(
   parameter int DEPTH = TRACE_DEPTH,
   parameter int SEQW  = TRACE_SEQW
) (
   input  logic                   clk,
   input  logic                   RN,
   input  logic                   cap_en,
   input  logic                   wb_valid,
   input  logic [31:0]            npc_in,
   input  logic [31:0]            wb_in,
   input  logic                   clear,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_npc,
   output logic [31:0]            out_wb,
   output logic [SEQW-1:0]        out_seq,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic [SEQW-1:0]        drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = entry_width(SEQW);

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [SEQW-1:0]  r_seq;
   logic [SEQW-1:0]  r_drop_cnt;

   logic             w_attempt;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_we;
   logic [ENT_W-1:0] w_wr_data;
   logic [ENT_W-1:0] w_rd_data;

   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_attempt = wb_valid & cap_en;
   assign w_pop     = ~w_empty & out_ready;
   // A pop in the same cycle frees a slot, so a full buffer still accepts.
   assign w_push    = w_attempt & (~w_full | w_pop);
   assign w_we      = w_push & ~clear;
   assign w_wr_data = {npc_in, wb_in, r_seq};

   sam_trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W),
      .AW    (PTR_W)
   ) u_ram (
      .clk   (clk),
      .we    (w_we),
      .waddr (r_wr_ptr),
      .wdata (w_wr_data),
      .raddr (r_rd_ptr),
      .rdata (w_rd_data)
   );

   always_ff @(posedge clk or negedge RN) begin
      if (!RN) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_seq      <= '0;
         r_drop_cnt <= '0;
      end else if (clear) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_seq      <= '0;
         r_drop_cnt <= '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end

         // Every capture attempt consumes a sequence number, kept or dropped.
         if (w_attempt) r_seq <= r_seq + SEQW'(1);

         if (w_attempt && !w_push && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + SEQW'(1);
         end
      end
   end

   assign out_valid = ~w_empty;
   assign out_npc   = w_rd_data[ENT_W-1 -: 32];
   assign out_wb    = w_rd_data[SEQW +: 32];
   assign out_seq   = w_rd_data[SEQW-1:0];
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = w_empty;
   assign drop_cnt  = r_drop_cnt;

endmodule
